// File: rtl/rv32i_pipe_pkg.sv
// Shared definitions for the RV32I six-register pipeline: hazard FSM states,
// register-address width, stage indices and the load-use match function.
package rv32i_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  // Stage register indices, used to address the stall/flush vectors.
  localparam int STG_PC      = 0;
  localparam int STG_SUB_IF  = 1;
  localparam int STG_IF      = 2;
  localparam int STG_ID      = 3;
  localparam int STG_EX      = 4;
  localparam int STG_SUB_MEM = 5;
  localparam int STG_MEM     = 6;
  localparam int NUM_STAGES  = 7;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIRECT = 2'd2,
    FREEZE   = 2'd3
  } hz_state_t;

  // True when an in-flight load writes a register the instruction in ID reads.
  // x0 is never a real producer.
  function automatic logic hz_load_use_hit(
    input logic                  valid,
    input logic                  memread,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  id_valid
  );
    return valid & memread & (rd != '0) & ((rd == rs1) | (rd == rs2)) & id_valid;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-controller bundle: pipeline status into the controller, per-stage
// stall/flush controls back out, plus debug state and performance counters.
interface hazard_ctrl_unit_if;
  import rv32i_pipe_pkg::*;

  logic                  id_valid_i;
  logic [REG_ADDR_W-1:0] id_rs1_addr_i;
  logic [REG_ADDR_W-1:0] id_rs2_addr_i;
  logic                  ex_valid_i;
  logic                  ex_memread_i;
  logic [REG_ADDR_W-1:0] ex_rd_addr_i;
  logic                  submem_valid_i;
  logic                  submem_memread_i;
  logic [REG_ADDR_W-1:0] submem_rd_addr_i;
  logic                  ex_take_bj_i;
  logic                  dmem_busy_i;

  logic stall_pc_o;
  logic stall_sub_if_o;
  logic stall_if_o;
  logic stall_id_o;
  logic stall_ex_o;
  logic stall_sub_mem_o;
  logic flush_sub_if_o;
  logic flush_if_o;
  logic flush_id_o;
  logic flush_ex_o;
  logic flush_sub_mem_o;
  logic flush_mem_o;
  logic [1:0]  state_o;
  logic [31:0] lu_stall_cnt_o;
  logic [31:0] redirect_cnt_o;
  logic [31:0] freeze_cnt_o;

  // Pipeline side: reports stage status, receives controls.
  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs2_addr_i,
           ex_valid_i, ex_memread_i, ex_rd_addr_i,
           submem_valid_i, submem_memread_i, submem_rd_addr_i,
           ex_take_bj_i, dmem_busy_i,
    input  stall_pc_o, stall_sub_if_o, stall_if_o, stall_id_o, stall_ex_o, stall_sub_mem_o,
           flush_sub_if_o, flush_if_o, flush_id_o, flush_ex_o, flush_sub_mem_o, flush_mem_o,
           state_o, lu_stall_cnt_o, redirect_cnt_o, freeze_cnt_o
  );

  // Controller side.
  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i,
           ex_valid_i, ex_memread_i, ex_rd_addr_i,
           submem_valid_i, submem_memread_i, submem_rd_addr_i,
           ex_take_bj_i, dmem_busy_i,
    output stall_pc_o, stall_sub_if_o, stall_if_o, stall_id_o, stall_ex_o, stall_sub_mem_o,
           flush_sub_if_o, flush_if_o, flush_id_o, flush_ex_o, flush_sub_mem_o, flush_mem_o,
           state_o, lu_stall_cnt_o, redirect_cnt_o, freeze_cnt_o
  );

endinterface

// File: rtl/hz_perf_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module hz_perf_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  // Count enabled cycles, holding at the maximum value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != 32'hFFFF_FFFF)) begin
      cnt_o <= cnt_o + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Central stall/flush controller for the six-register RV32I pipeline.
// Handles load-use bubbles, redirect flushes and data-memory freezes.
// Define HAZARD_PERF_CNT_EN to build the load-use/redirect/freeze event
// counters; otherwise the counter outputs read as zero.
module hazard_ctrl_unit
  import rv32i_pipe_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 2,
  parameter int unsigned REDIRECT_CYCLES = 1
) (
  input logic               clk_i,
  input logic               rst_i,
  hazard_ctrl_unit_if.slave hz
);

  // Total bubble cycles for an ID/EX producer and a sub-MEM producer.
  localparam logic [2:0] LU_EX_BUBBLES = 3'(LOAD_USE_CYCLES);
  localparam logic [2:0] LU_SM_BUBBLES = 3'(LOAD_USE_CYCLES - 1);
  localparam logic [2:0] RD_CYCLES     = 3'(REDIRECT_CYCLES);

  hz_state_t state_q, state_d;
  hz_state_t saved_q, saved_d;
  hz_state_t eff_state, cur_state;
  logic [2:0] cnt_q, cnt_d;
  logic ex_hit, sm_hit;
  logic [NUM_STAGES-1:0] stall_vec, flush_vec, stall_out, flush_out;

  assign ex_hit = hz_load_use_hit(hz.ex_valid_i, hz.ex_memread_i, hz.ex_rd_addr_i,
                                  hz.id_rs1_addr_i, hz.id_rs2_addr_i, hz.id_valid_i);
  assign sm_hit = hz_load_use_hit(hz.submem_valid_i, hz.submem_memread_i, hz.submem_rd_addr_i,
                                  hz.id_rs1_addr_i, hz.id_rs2_addr_i, hz.id_valid_i);

  // Next-state and stage controls; leaving FREEZE resumes the saved state in the same cycle.
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    stall_vec = '0;
    flush_vec = '0;
    eff_state = (state_q == FREEZE) ? saved_q : state_q;
    cur_state = eff_state;

    if (hz.dmem_busy_i) begin
      cur_state = FREEZE;
      state_d   = FREEZE;
      saved_d   = eff_state;
      stall_vec[STG_PC]      = 1'b1;
      stall_vec[STG_SUB_IF]  = 1'b1;
      stall_vec[STG_IF]      = 1'b1;
      stall_vec[STG_ID]      = 1'b1;
      stall_vec[STG_EX]      = 1'b1;
      stall_vec[STG_SUB_MEM] = 1'b1;
    end else if (hz.ex_take_bj_i) begin
      saved_d = RUN;
      flush_vec[STG_SUB_IF] = 1'b1;
      flush_vec[STG_IF]     = 1'b1;
      flush_vec[STG_ID]     = 1'b1;
      if (RD_CYCLES != 3'd0) begin
        state_d = REDIRECT;
        cnt_d   = RD_CYCLES;
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else begin
      saved_d = RUN;
      state_d = eff_state;
      case (eff_state)
        RUN: begin
          cnt_d = '0;
          if (ex_hit || (sm_hit && (LU_SM_BUBBLES != 3'd0))) begin
            stall_vec[STG_PC]     = 1'b1;
            stall_vec[STG_SUB_IF] = 1'b1;
            stall_vec[STG_IF]     = 1'b1;
            flush_vec[STG_ID]     = 1'b1;
            cnt_d   = ex_hit ? (LU_EX_BUBBLES - 3'd1) : (LU_SM_BUBBLES - 3'd1);
            state_d = (cnt_d != 3'd0) ? LU_STALL : RUN;
          end
        end
        LU_STALL: begin
          stall_vec[STG_PC]     = 1'b1;
          stall_vec[STG_SUB_IF] = 1'b1;
          stall_vec[STG_IF]     = 1'b1;
          flush_vec[STG_ID]     = 1'b1;
          cnt_d   = (cnt_q <= 3'd1) ? 3'd0 : (cnt_q - 3'd1);
          state_d = (cnt_q <= 3'd1) ? RUN : LU_STALL;
        end
        REDIRECT: begin
          flush_vec[STG_IF] = 1'b1;
          cnt_d   = (cnt_q <= 3'd1) ? 3'd0 : (cnt_q - 3'd1);
          state_d = (cnt_q <= 3'd1) ? RUN : REDIRECT;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, saved state and bubble/redirect counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_out = rst_i ? '0 : stall_vec;
  assign flush_out = rst_i ? '0 : flush_vec;

  assign hz.stall_pc_o      = stall_out[STG_PC];
  assign hz.stall_sub_if_o  = stall_out[STG_SUB_IF];
  assign hz.stall_if_o      = stall_out[STG_IF];
  assign hz.stall_id_o      = stall_out[STG_ID];
  assign hz.stall_ex_o      = stall_out[STG_EX];
  assign hz.stall_sub_mem_o = stall_out[STG_SUB_MEM];
  assign hz.flush_sub_if_o  = flush_out[STG_SUB_IF];
  assign hz.flush_if_o      = flush_out[STG_IF];
  assign hz.flush_id_o      = flush_out[STG_ID];
  assign hz.flush_ex_o      = 1'b0;
  assign hz.flush_sub_mem_o = 1'b0;
  assign hz.flush_mem_o     = 1'b0;
  assign hz.state_o         = rst_i ? 2'd0 : cur_state;

`ifdef HAZARD_PERF_CNT_EN
  logic        lu_evt, rd_evt, fz_evt;
  logic [31:0] lu_cnt, rd_cnt, fz_cnt;

  // A PC stall outside a freeze is always a load-use bubble.
  assign lu_evt = stall_vec[STG_PC] & ~hz.dmem_busy_i;
  assign rd_evt = hz.ex_take_bj_i & ~hz.dmem_busy_i;
  assign fz_evt = hz.dmem_busy_i;

  hz_perf_counter u_lu_cnt (.clk_i(clk_i), .rst_i(rst_i), .en_i(lu_evt), .cnt_o(lu_cnt));
  hz_perf_counter u_rd_cnt (.clk_i(clk_i), .rst_i(rst_i), .en_i(rd_evt), .cnt_o(rd_cnt));
  hz_perf_counter u_fz_cnt (.clk_i(clk_i), .rst_i(rst_i), .en_i(fz_evt), .cnt_o(fz_cnt));

  assign hz.lu_stall_cnt_o = lu_cnt;
  assign hz.redirect_cnt_o = rd_cnt;
  assign hz.freeze_cnt_o   = fz_cnt;
`else
  assign hz.lu_stall_cnt_o = '0;
  assign hz.redirect_cnt_o = '0;
  assign hz.freeze_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with default parameters
// (LOAD_USE_CYCLES=2, REDIRECT_CYCLES=1).
// Observed word per cycle: {stall[pc,sub_if,if,id,ex,sub_mem], flush[sub_if,if,id,ex,sub_mem,mem], state}.
module tb_hazard_ctrl_unit;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl_unit_if hz_if ();

  hazard_ctrl_unit #(.LOAD_USE_CYCLES(2), .REDIRECT_CYCLES(1)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .hz(hz_if)
  );

  always #5 clk_i = ~clk_i;

  logic [5:0]  obs_stall;
  logic [5:0]  obs_flush;
  logic [13:0] obs;
  logic [13:0] exp_w;

  assign obs_stall = {hz_if.stall_pc_o, hz_if.stall_sub_if_o, hz_if.stall_if_o,
                      hz_if.stall_id_o, hz_if.stall_ex_o, hz_if.stall_sub_mem_o};
  assign obs_flush = {hz_if.flush_sub_if_o, hz_if.flush_if_o, hz_if.flush_id_o,
                      hz_if.flush_ex_o, hz_if.flush_sub_mem_o, hz_if.flush_mem_o};
  assign obs = {obs_stall, obs_flush, hz_if.state_o};

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_LU   = 6'b111000;
  localparam logic [5:0] S_ALL  = 6'b111111;
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_LU   = 6'b001000;
  localparam logic [5:0] F_BJ   = 6'b111000;
  localparam logic [5:0] F_RD   = 6'b010000;

  task clear_inputs();
    hz_if.id_valid_i       = 1'b0;
    hz_if.id_rs1_addr_i    = '0;
    hz_if.id_rs2_addr_i    = '0;
    hz_if.ex_valid_i       = 1'b0;
    hz_if.ex_memread_i     = 1'b0;
    hz_if.ex_rd_addr_i     = '0;
    hz_if.submem_valid_i   = 1'b0;
    hz_if.submem_memread_i = 1'b0;
    hz_if.submem_rd_addr_i = '0;
    hz_if.ex_take_bj_i     = 1'b0;
    hz_if.dmem_busy_i      = 1'b0;
  endtask

  task next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task set_ex_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    hz_if.id_valid_i    = 1'b1;
    hz_if.id_rs1_addr_i = rs1;
    hz_if.id_rs2_addr_i = rs2;
    hz_if.ex_valid_i    = 1'b1;
    hz_if.ex_memread_i  = 1'b1;
    hz_if.ex_rd_addr_i  = rd;
  endtask

  task test_reset();
    clear_inputs();
    set_ex_load(5'd5, 5'd5, 5'd0);
    hz_if.ex_take_bj_i = 1'b1;
    @(negedge clk_i);
    exp_w = {S_NONE, F_NONE, 2'd0};
    vectors++;
    if (obs !== exp_w) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: got %b required %b", obs, exp_w);
    end
    next_cycle();
    rst_i = 1'b0;
    clear_inputs();
    @(negedge clk_i);
    vectors++;
    if (obs !== exp_w) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got %b required %b", obs, exp_w);
    end
`ifndef HAZARD_PERF_CNT_EN
    vectors++;
    if ({hz_if.lu_stall_cnt_o, hz_if.redirect_cnt_o, hz_if.freeze_cnt_o} !== 96'd0) begin
      miscompares++;
      $display("[TB] FAIL perf_tied_zero: got %h required 0",
               {hz_if.lu_stall_cnt_o, hz_if.redirect_cnt_o, hz_if.freeze_cnt_o});
    end
`endif
  endtask

  task test_ex_load_use();
    logic [13:0] exp_seq [3];
    exp_seq[0] = {S_LU, F_LU, 2'd0};
    exp_seq[1] = {S_LU, F_LU, 2'd1};
    exp_seq[2] = {S_NONE, F_NONE, 2'd0};
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      clear_inputs();
      if (c == 0) set_ex_load(5'd5, 5'd5, 5'd9);
      @(negedge clk_i);
      vectors++;
      if (obs !== exp_seq[c]) begin
        miscompares++;
        $display("[TB] FAIL ex_load_use c%0d: got %b required %b", c, obs, exp_seq[c]);
      end
    end
  endtask

  task test_submem_load_use();
    logic [13:0] exp_seq [2];
    exp_seq[0] = {S_LU, F_LU, 2'd0};
    exp_seq[1] = {S_NONE, F_NONE, 2'd0};
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      clear_inputs();
      if (c == 0) begin
        hz_if.id_valid_i       = 1'b1;
        hz_if.id_rs1_addr_i    = 5'd3;
        hz_if.id_rs2_addr_i    = 5'd7;
        hz_if.ex_valid_i       = 1'b1;
        hz_if.ex_memread_i     = 1'b0;
        hz_if.ex_rd_addr_i     = 5'd7;
        hz_if.submem_valid_i   = 1'b1;
        hz_if.submem_memread_i = 1'b1;
        hz_if.submem_rd_addr_i = 5'd7;
      end
      @(negedge clk_i);
      vectors++;
      if (obs !== exp_seq[c]) begin
        miscompares++;
        $display("[TB] FAIL submem_load_use c%0d: got %b required %b", c, obs, exp_seq[c]);
      end
    end
  endtask

  task test_no_hazard();
    exp_w = {S_NONE, F_NONE, 2'd0};
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      clear_inputs();
      case (c)
        0: set_ex_load(5'd0, 5'd0, 5'd0);
        1: begin
          hz_if.id_valid_i       = 1'b1;
          hz_if.submem_valid_i   = 1'b1;
          hz_if.submem_memread_i = 1'b1;
          hz_if.submem_rd_addr_i = 5'd0;
        end
        2: set_ex_load(5'd3, 5'd4, 5'd6);
        default: begin
          set_ex_load(5'd8, 5'd8, 5'd8);
          hz_if.id_valid_i = 1'b0;
        end
      endcase
      @(negedge clk_i);
      vectors++;
      if (obs !== exp_w) begin
        miscompares++;
        $display("[TB] FAIL no_hazard c%0d: got %b required %b", c, obs, exp_w);
      end
    end
  endtask

  task test_redirect();
    logic [13:0] exp_seq [3];
    exp_seq[0] = {S_NONE, F_BJ, 2'd0};
    exp_seq[1] = {S_NONE, F_RD, 2'd2};
    exp_seq[2] = {S_NONE, F_NONE, 2'd0};
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      clear_inputs();
      if (c == 0) hz_if.ex_take_bj_i = 1'b1;
      @(negedge clk_i);
      vectors++;
      if (obs !== exp_seq[c]) begin
        miscompares++;
        $display("[TB] FAIL redirect c%0d: got %b required %b", c, obs, exp_seq[c]);
      end
    end
  endtask

  task test_redirect_abort_restart();
    logic [13:0] exp_seq [6];
    exp_seq[0] = {S_LU, F_LU, 2'd0};
    exp_seq[1] = {S_NONE, F_BJ, 2'd1};
    exp_seq[2] = {S_NONE, F_BJ, 2'd2};
    exp_seq[3] = {S_NONE, F_RD, 2'd2};
    exp_seq[4] = {S_NONE, F_NONE, 2'd0};
    exp_seq[5] = {S_NONE, F_NONE, 2'd0};
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      clear_inputs();
      if (c == 0) set_ex_load(5'd12, 5'd0, 5'd12);
      if (c == 1 || c == 2) hz_if.ex_take_bj_i = 1'b1;
      @(negedge clk_i);
      vectors++;
      if (obs !== exp_seq[c]) begin
        miscompares++;
        $display("[TB] FAIL redirect_abort_restart c%0d: got %b required %b", c, obs, exp_seq[c]);
      end
    end
  endtask

  task test_freeze();
    logic [13:0] exp_seq [8];
    exp_seq[0] = {S_LU, F_LU, 2'd0};
    exp_seq[1] = {S_ALL, F_NONE, 2'd3};
    exp_seq[2] = {S_ALL, F_NONE, 2'd3};
    exp_seq[3] = {S_ALL, F_NONE, 2'd3};
    exp_seq[4] = {S_LU, F_LU, 2'd1};
    exp_seq[5] = {S_NONE, F_NONE, 2'd0};
    exp_seq[6] = {S_ALL, F_NONE, 2'd3};
    exp_seq[7] = {S_NONE, F_NONE, 2'd0};
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      clear_inputs();
      if (c == 0) set_ex_load(5'd5, 5'd5, 5'd0);
      if (c >= 1 && c <= 3) hz_if.dmem_busy_i = 1'b1;
      if (c == 2) begin
        hz_if.ex_take_bj_i = 1'b1;
        set_ex_load(5'd6, 5'd6, 5'd0);
      end
      if (c == 6) hz_if.dmem_busy_i = 1'b1;
      @(negedge clk_i);
      vectors++;
      if (obs !== exp_seq[c]) begin
        miscompares++;
        $display("[TB] FAIL freeze c%0d: got %b required %b", c, obs, exp_seq[c]);
      end
    end
  endtask

  task test_reset_mid_stall();
    next_cycle();
    clear_inputs();
    set_ex_load(5'd5, 5'd5, 5'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk_i);
    exp_w = {S_LU, F_LU, 2'd1};
    vectors++;
    if (obs !== exp_w) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_pre: got %b required %b", obs, exp_w);
    end
    #1;
    rst_i = 1'b1;
    #1;
    exp_w = {S_NONE, F_NONE, 2'd0};
    vectors++;
    if (obs !== exp_w) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_async: got %b required %b", obs, exp_w);
    end
    next_cycle();
    rst_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      vectors++;
      if (obs !== exp_w) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_after c%0d: got %b required %b", c, obs, exp_w);
      end
      next_cycle();
    end
  endtask

  initial begin
    $display("[TB] hazard_ctrl_unit directed test start");
    test_reset();
    test_ex_load_use();
    test_submem_load_use();
    test_no_hazard();
    test_redirect();
    test_redirect_abort_restart();
    test_freeze();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Central stall/flush controller for the RV32I six-register pipeline: PC, sub-IF, IF/ID, ID/EX, sub-MEM, MEM.
- Detects load-use hazards against the two in-flight load stages, sequences redirect flushes after a taken branch/jump, and freezes the whole pipeline while data memory is busy.
- Drives every stage's stall_*/flush_* control and replaces the ad-hoc stall/flush wires in the pipeline top.

Parameters:
- LOAD_USE_CYCLES, 2, bubbles inserted when the producing load is in ID/EX; a sub-MEM producer gets LOAD_USE_CYCLES-1. Legal range 1..7.
- REDIRECT_CYCLES, 1, extra cycles flush_if_o stays high after a redirect to cover the instruction BRAM read latency. Legal range 0..3.

Ports:
- clk_i in 1: clock
- rst_i in 1: reset, asynchronous, active-high
- id_valid_i in 1: IF/ID holds a valid instruction
- id_rs1_addr_i in 5: decoded rs1 source address in ID (0 when unused)
- id_rs2_addr_i in 5: decoded rs2 source address in ID (0 when unused)
- ex_valid_i in 1: ID/EX valid
- ex_memread_i in 1: ID/EX instruction is a load
- ex_rd_addr_i in 5: ID/EX destination register
- submem_valid_i in 1: sub-MEM valid
- submem_memread_i in 1: sub-MEM instruction is a load
- submem_rd_addr_i in 5: sub-MEM destination register
- ex_take_bj_i in 1: taken branch/jump resolved in EX this cycle
- dmem_busy_i in 1: data memory not ready
- stall_pc_o, stall_sub_if_o, stall_if_o, stall_id_o, stall_ex_o, stall_sub_mem_o out 1 each: hold the named stage register
- flush_sub_if_o, flush_if_o, flush_id_o, flush_ex_o, flush_sub_mem_o, flush_mem_o out 1 each: clear the named stage register to a bubble
- state_o out 2: current FSM state, for debug

Behaviour:
- Reset: asynchronous. State = RUN, counter = 0, saved state = RUN. While rst_i is high, all outputs are forced to 0.
- States: RUN=0, LU_STALL=1, REDIRECT=2, FREEZE=3.
- Hazard hit:
  - ex_hit = ex_valid_i & ex_memread_i & ex_rd_addr_i!=0 & (rd==id_rs1_addr_i | rd==id_rs2_addr_i) & id_valid_i.
  - sm_hit uses the same equation on the submem_* inputs.
- Priority each cycle: dmem_busy_i > ex_take_bj_i > load-use > normal flow.
- FREEZE (entered from any state when dmem_busy_i=1):
  - Save the current state; the counter does not decrement.
  - All six stall_* outputs = 1; all flush_* outputs = 0.
  - Returns to the saved state in the first cycle dmem_busy_i=0.
  - Hazard and redirect inputs are ignored while frozen.
- Redirect (ex_take_bj_i=1, no busy, any non-FREEZE state):
  - Same cycle: flush_sub_if_o = flush_if_o = flush_id_o = 1; all stalls = 0 so the PC loads the target.
  - Aborts any LU_STALL in progress.
  - If REDIRECT_CYCLES>0: go to REDIRECT, counter = REDIRECT_CYCLES.
- REDIRECT: flush_if_o=1; decrement counter; return to RUN when counter reaches 1. A new ex_take_bj_i restarts the sequence.
- Load-use (in RUN, ex_hit | sm_hit):
  - Same cycle: stall_pc_o = stall_sub_if_o = stall_if_o = 1, flush_id_o = 1 (bubble into ID/EX).
  - Counter = ex_hit ? LOAD_USE_CYCLES-1 : LOAD_USE_CYCLES-2.
  - Go to LU_STALL if counter>0, else stay in RUN.
- LU_STALL: same outputs as the load-use cycle; decrement counter; return to RUN after the cycle where counter=1. Hazard inputs are not re-evaluated until RUN.
- stall_id_o, stall_ex_o, stall_sub_mem_o, flush_ex_o, flush_sub_mem_o, flush_mem_o are asserted only by FREEZE (stalls); the flushes are reserved and tied 0.
- All outputs are combinational from state, counter and inputs (zero-cycle response). State and counter are registered. Counter width is 3 bits.

Optional Feature:
- HAZARD_PERF_CNT_EN: adds outputs lu_stall_cnt_o[31:0], redirect_cnt_o[31:0], freeze_cnt_o[31:0].
  - lu_stall_cnt_o counts load-use bubble cycles.
  - redirect_cnt_o counts ex_take_bj_i events.
  - freeze_cnt_o counts FREEZE cycles.
  - All saturate at 0xFFFFFFFF and reset to 0.
- Without the macro these ports still exist, tied to 0, and no counter logic is built.

Decomposition:
- Shared package rv32i_pipe_pkg:
  - hz_state_t enum (RUN/LU_STALL/REDIRECT/FREEZE)
  - register-address width constant REG_ADDR_W=5
  - stage index constants
- Sub-module hz_perf_counter: one 32-bit saturating counter with enable, instantiated three times under HAZARD_PERF_CNT_EN.

Test Plan:
- ID/EX load with rd=x5 and ex_memread=1, ID rs1=x5 -> cycles 0-1: stall_pc/if = 1, flush_id = 1; state_o=1 in cycle 1; RUN and stalls=0 in cycle 2.
- sub-MEM load rd=x7, ID rs2=x7, ID/EX not a load -> exactly 1 stall cycle; state_o stays 0.
- Load with rd=x0, ID rs1=x0 -> no stall, no flush.
- ex_take_bj_i pulse -> cycle 0: flush_sub_if/if/id = 1, stall_pc=0; cycle 1: only flush_if=1, state_o=2; cycle 2: RUN.
- LU_STALL entered, then dmem_busy_i high 3 cycles -> all stalls=1 and flushes=0 for 3 cycles, state_o=3; then 1 remaining LU_STALL cycle, then RUN.
- rst_i asserted mid-LU_STALL -> all outputs 0 immediately; after release state_o=0 with no residual stall.
